// File: rtl/uart_rx_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl_pkg
//   Shared types and constants for the UART receive frame controller.
//   - state_t    : frame controller FSM states
//   - err_code_t : cause of the most recent discarded frame
//   - DEFAULT_SYNC_BYTE : frame start marker used when not overridden
// ---------------------------------------------------------------------------
package uart_rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_BAD_SUM = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_frame_ctrl_frame_buffer.sv
// ---------------------------------------------------------------------------
// frame_buffer
//   DEPTH x 8 payload store. One synchronous write port, one asynchronous
//   read port. Addresses at or beyond DEPTH write nothing and read zero, so
//   the controller's index may sit one past the last entry without harm.
//
//   Ports:
//     clock    in   system clock
//     wr_en    in   write strobe
//     wr_addr  in   write address (AW bits)
//     wr_data  in   byte to store
//     rd_addr  in   read address (AW bits)
//     rd_data  out  byte at rd_addr (combinational)
// ---------------------------------------------------------------------------
module frame_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 5
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Address decode by comparison keeps AW independent of the array depth.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
                mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
//   Frame-level controller behind the UART receiver. Frames are
//   SYNC, LEN, LEN payload bytes, XOR checksum (LEN ^ payload). Payload is
//   buffered and released on a valid/ready stream only after the checksum
//   matches; bad length, bad checksum or an inter-byte gap longer than
//   TIMEOUT_CYCLES discards the frame with an error code.
//
//   Ports:
//     clock      in   system clock
//     reset      in   synchronous active-high reset
//     rx_data    in   received byte, sampled only while rx_done=1
//     rx_done    in   one-cycle byte-complete strobe
//     out_data   out  payload byte
//     out_valid  out  out_data valid
//     out_ready  in   downstream accepts when out_valid & out_ready
//     out_last   out  final payload byte of the frame
//     frame_ok   out  one-cycle pulse: frame accepted, drain starts
//     frame_err  out  one-cycle pulse: frame discarded
//     err_code   out  cause of last frame_err, held until the next one
//     rx_drop    out  one-cycle pulse: byte discarded during drain
//     busy       out  controller not idle
//     state_dbg  out  current FSM state
//
//   Output stream handshake: a byte transfers on any rising clock edge where
//   out_valid and out_ready are both high. Once out_valid rises it stays high,
//   with out_data and out_last unchanged, until that transfer happens;
//   out_valid never depends on out_ready.
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 10420
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       rx_drop,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int         IW        = $clog2(MAX_LEN + 1);
    localparam int         TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    err_code_t     err_q, err_d;
    logic          ok_q, ok_d;
    logic          ferr_q, ferr_d;
    logic          drop_q, drop_d;
    logic          buf_we;
    logic [7:0]    buf_rd;
    logic          tmo_expired;

    frame_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (IW)
    ) u_buf (
        .clock   (clock),
        .wr_en   (buf_we),
        .wr_addr (idx_q),
        .wr_data (rx_data),
        .rd_addr (idx_q),
        .rd_data (buf_rd)
    );

    assign tmo_expired = (tmo_q == TMO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            tmo_q   <= '0;
            err_q   <= ERR_NONE;
            ok_q    <= 1'b0;
            ferr_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
            ferr_q  <= ferr_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        ok_d    = 1'b0;
        ferr_d  = 1'b0;
        drop_d  = 1'b0;
        buf_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_done && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                    tmo_d   = '0;
                end
            end

            ST_LEN: begin
                if (rx_done) begin
                    tmo_d = '0;
                    if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                        state_d = ST_IDLE;
                        ferr_d  = 1'b1;
                        err_d   = ERR_BAD_LEN;
                    end else begin
                        state_d = ST_PAYLOAD;
                        len_d   = rx_data[IW-1:0];
                        sum_d   = rx_data;
                        idx_d   = '0;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_PAYLOAD: begin
                if (rx_done) begin
                    tmo_d  = '0;
                    buf_we = 1'b1;
                    sum_d  = sum_q ^ rx_data;
                    idx_d  = idx_q + IW'(1);
                    if (idx_q == (len_q - IW'(1))) begin
                        state_d = ST_CHECK;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_CHECK: begin
                if (rx_done) begin
                    tmo_d = '0;
                    if (rx_data == sum_q) begin
                        state_d = ST_DRAIN;
                        ok_d    = 1'b1;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        ferr_d  = 1'b1;
                        err_d   = ERR_BAD_SUM;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_DRAIN: begin
                // Bytes arriving now cannot be framed; the drain is not
                // interrupted and SYNC is deliberately not looked for.
                drop_d = rx_done;
                if (out_ready) begin
                    if (idx_q == (len_q - IW'(1))) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stream outputs decode from registered state only.
    assign out_valid = (state_q == ST_DRAIN);
    assign out_last  = (state_q == ST_DRAIN) && (idx_q == (len_q - IW'(1)));
    assign out_data  = buf_rd;
    assign frame_ok  = ok_q;
    assign frame_err = ferr_q;
    assign err_code  = err_q;
    assign rx_drop   = drop_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule
